// File: rtl/sm_0535_pwm_capture.sv
// PWM receive-side monitor: measures high time and period of an asynchronous
// PWM line and reports duty cycle in percent via a restoring divider.
module sm_0535_pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [6:0]       duty,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             overrun
);

  localparam int unsigned NW   = CNT_W + 7;
  localparam int unsigned IT_W = $clog2(NW);

  typedef enum logic [1:0] {IDLE, ARMED, DIVIDE, DONE} state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_e;
  logic [CNT_W-1:0] cnt_p_q, cnt_h_q;
  logic [CNT_W-1:0] cnt_p_d, cnt_h_d;
  logic [CNT_W-1:0] hl_q, pl_q;
  logic [NW-1:0]    num_q, num_d, num_init;
  logic [CNT_W:0]   rem_q, rem_d, rem_sh;
  logic [IT_W-1:0]  it_q;
  logic             ge;
  logic             tmo_hit;
  logic [6:0]       duty_q, duty_d;
  logic [CNT_W-1:0] high_q, period_q;
  logic             valid_q, timeout_q, overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_e = sync2_q & ~sync3_q;

  always_comb begin
    cnt_p_d  = (cnt_p_q == '1) ? cnt_p_q : cnt_p_q + CNT_W'(1);
    cnt_h_d  = (cnt_h_q == '1 || !sync2_q) ? cnt_h_q : cnt_h_q + CNT_W'(1);
    num_init = NW'(cnt_h_q) * NW'(100);
    rem_sh   = {rem_q[CNT_W-1:0], num_q[NW-1]};
    ge       = (rem_sh >= {1'b0, pl_q});
    rem_d    = ge ? rem_sh - {1'b0, pl_q} : rem_sh;
    num_d    = {num_q[NW-2:0], ge};
    duty_d   = (num_q > NW'(100)) ? 7'd100 : num_q[6:0];
    // Also armed in IDLE so a line stuck from reset is reported; the exact
    // compare fires once because cnt_p runs past TIMEOUT-1 afterwards.
    tmo_hit  = !edge_e && (cnt_p_q == CNT_W'(TIMEOUT - 1)) &&
               (state_q == IDLE || state_q == ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p_q <= '0;
      cnt_h_q <= '0;
    end else if (edge_e) begin
      cnt_p_q <= '0;
      cnt_h_q <= CNT_W'(1);
    end else begin
      cnt_p_q <= cnt_p_d;
      cnt_h_q <= cnt_h_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hl_q      <= '0;
      pl_q      <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      it_q      <= '0;
      duty_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (edge_e) state_q <= ARMED;
        ARMED: begin
          if (edge_e) begin
            hl_q    <= cnt_h_q;
            pl_q    <= cnt_p_d;
            num_q   <= num_init;
            rem_q   <= '0;
            it_q    <= '0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (edge_e) overrun_q <= 1'b1;
          num_q <= num_d;
          rem_q <= rem_d;
          it_q  <= it_q + IT_W'(1);
          if (it_q == IT_W'(NW - 1)) state_q <= DONE;
        end
        DONE: begin
          if (edge_e) overrun_q <= 1'b1;
          duty_q    <= duty_d;
          high_q    <= hl_q;
          period_q  <= pl_q;
          valid_q   <= 1'b1;
          timeout_q <= 1'b0;
          state_q   <= ARMED;
        end
        default: state_q <= IDLE;
      endcase
      if (tmo_hit) begin
        duty_q    <= sync2_q ? 7'd100 : 7'd0;
        high_q    <= sync2_q ? CNT_W'(TIMEOUT) : '0;
        period_q  <= CNT_W'(TIMEOUT);
        timeout_q <= 1'b1;
        valid_q   <= 1'b1;
        state_q   <= IDLE;
      end
    end
  end

  assign duty      = duty_q;
  assign high_time = high_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;

endmodule
